ahb_fetch_master: RTL

Instruction-fetch AHB-Lite master sitting directly upstream of the instruction-memory slave. Issues single-word, non-pipelined read transfers at a sequential program counter, buffers returned words in a small prefetch FIFO, and presents them to the core through a valid/ready handshake. Supports a redirect (branch/jump) that flushes buffered and in-flight fetches and restarts at a new address.

---
 rtl/ahb_fetch_master.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/ahb_fetch_master.sv
// Instruction-fetch AHB-Lite master with a show-ahead prefetch FIFO.
// One non-pipelined word read in flight; redirect flushes and restarts.
module ahb_fetch_master #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 4
) (
  input  logic        HCLK,
  input  logic        HRESETn,
  input  logic        fetch_en,
  output logic [31:0] HADDR,
  output logic [1:0]  HTRANS,
  output logic        HWRITE,
  output logic [2:0]  HSIZE,
  output logic [31:0] HWDATA,
  input  logic [31:0] HRDATA,
  input  logic        HREADY,
  input  logic [1:0]  HRESP,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        instr_valid,
  output logic [31:0] instr_data,
  output logic [31:0] instr_pc,
  input  logic        instr_ready
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  typedef enum logic [1:0] {
    IDLE,
    ADDR,
    DATA
  } state_t;

  state_t        state;
  logic [31:0]   pc;
  logic [31:0]   pc_nxt;
  logic [31:0]   haddr;
  logic          drop;

  logic [31:0]   fifo_data [DEPTH];
  logic [31:0]   fifo_pc   [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic [CW-1:0] count_nxt;

  logic          done;
  logic          push;
  logic          pop;
  logic          room;

  // The slave always answers OKAY; the low pc bits are forced to zero.
  logic unused_in;
  assign unused_in = ^{HRESP, redirect_pc[1:0]};

  assign HADDR  = haddr;
  assign HTRANS = (state == ADDR) ? 2'b10 : 2'b00;
  assign HWRITE = 1'b0;
  assign HSIZE  = 3'b010;
  assign HWDATA = 32'h0;

  assign instr_valid = (count != '0);
  assign instr_data  = fifo_data[rd_ptr];
  assign instr_pc    = fifo_pc[rd_ptr];

  assign done = (state == DATA) && HREADY;
  assign push = done && !drop && !redirect_valid;
  assign pop  = instr_valid && instr_ready && !redirect_valid;
  assign room = (count_nxt < DEPTH_C);

  // Occupancy after this edge; a redirect empties the FIFO.
  always_comb begin
    count_nxt = count;
    if (redirect_valid)
      count_nxt = '0;
    else if (push && !pop)
      count_nxt = count + 1'b1;
    else if (!push && pop)
      count_nxt = count - 1'b1;
  end

  // Next fetch address: redirect beats the post-transfer increment.
  always_comb begin
    pc_nxt = pc;
    if (redirect_valid)
      pc_nxt = {redirect_pc[31:2], 2'b00};
    else if (done && !drop)
      pc_nxt = pc + 32'd4;
  end

  // Transfer FSM with pc, bus address and the discard flag.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state <= IDLE;
      pc    <= RESET_PC;
      haddr <= RESET_PC;
      drop  <= 1'b0;
    end else begin
      pc <= pc_nxt;
      if (!(state == ADDR && !HREADY))
        haddr <= pc_nxt;
      if (done)
        drop <= 1'b0;
      else if (redirect_valid && state != IDLE)
        drop <= 1'b1;
      unique case (state)
        IDLE: if (fetch_en && room) state <= ADDR;
        ADDR: if (HREADY) state <= DATA;
        DATA: if (HREADY) state <= (fetch_en && room) ? ADDR : IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Prefetch FIFO storage and pointers.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        fifo_data[i] <= 32'h0;
        fifo_pc[i]   <= 32'h0;
      end
    end else if (redirect_valid) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        fifo_data[wr_ptr] <= HRDATA;
        fifo_pc[wr_ptr]   <= pc;
        wr_ptr            <= wr_ptr + 1'b1;
      end
      if (pop)
        rd_ptr <= rd_ptr + 1'b1;
      count <= count_nxt;
    end
  end

endmodule
